// File: rtl/bcd_seq_pkg.sv
// bcd_seq_pkg: shared state type and BCD constants for the digit-serial adder.
package bcd_seq_pkg;
  typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;
  localparam int DIGIT_W = 4;
  localparam logic [4:0] BCD_MAX = 5'd9;
  localparam logic [4:0] BCD_ADJ = 5'd6;
endpackage

// File: rtl/bcd_digit_add.sv
// bcd_digit_add: combinational one-digit BCD adder with decimal carry.
module bcd_digit_add
  import bcd_seq_pkg::*;
(
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       cout
);
  logic [4:0] sum;
  always_comb begin
    sum  = {1'b0, a} + {1'b0, b} + {4'b0, cin};
    cout = sum > BCD_MAX;
    s    = cout ? sum[3:0] + BCD_ADJ[3:0] : sum[3:0];
  end
endmodule

// File: rtl/bcd_add_seq.sv
// bcd_add_seq: digit-serial BCD adder sequencer, LSD first, one digit per clock.
// Optional invalid-digit flag on err when BCD_SEQ_ERR_EN is defined.
module bcd_add_seq
  import bcd_seq_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                    MAX10_CLK1_50,
  input  logic                    RESET_N,
  input  logic [3:0]              digit_in,
  input  logic                    load_a,
  input  logic                    load_b,
  input  logic                    clear,
  input  logic                    start,
  output logic                    busy,
  output logic                    done,
  output logic [4*DIGITS-1:0]     result,
  output logic                    cout,
  output logic                    err
);
  localparam int W  = DIGIT_W * DIGITS;
  localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;
  state_t          state;
  logic [W-1:0]    a_reg, b_reg;
  logic [IW-1:0]   idx;
  logic            carry;
  logic [3:0]      da, db, ds;
  logic            dc, last;
  always_comb begin
    da = '0;
    db = '0;
    for (int i = 0; i < DIGITS; i++)
      if (idx == IW'(i)) begin
        da = a_reg[4*i +: 4];
        db = b_reg[4*i +: 4];
      end
    last = idx == IW'(DIGITS - 1);
  end
  bcd_digit_add u_add (.a(da), .b(db), .cin(carry), .s(ds), .cout(dc));
  always_ff @(posedge MAX10_CLK1_50) begin
    if (!RESET_N) begin
      state  <= IDLE;
      a_reg  <= '0;
      b_reg  <= '0;
      result <= '0;
      idx    <= '0;
      carry  <= 1'b0;
      cout   <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (clear) begin
            a_reg  <= '0;
            b_reg  <= '0;
            result <= '0;
            cout   <= 1'b0;
          end else if (start) begin
            state  <= ADD;
            busy   <= 1'b1;
            idx    <= '0;
            carry  <= 1'b0;
            result <= '0;
            cout   <= 1'b0;
          end else begin
            // calculator-style entry: new digit enters at the LSD, MSD falls off
            if (load_a) a_reg <= W'({a_reg, digit_in});
            if (load_b) b_reg <= W'({b_reg, digit_in});
          end
        end
        ADD: begin
          for (int i = 0; i < DIGITS; i++)
            if (idx == IW'(i)) result[4*i +: 4] <= ds;
          carry <= dc;
          idx   <= idx + 1'b1;
          if (last) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            cout  <= dc;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
`ifdef BCD_SEQ_ERR_EN
  always_ff @(posedge MAX10_CLK1_50) begin
    if (!RESET_N) err <= 1'b0;
    else if (state == IDLE) begin
      if (clear) err <= 1'b0;
      else if (!start && (load_a || load_b) && {1'b0, digit_in} > BCD_MAX) err <= 1'b1;
    end else if (state == ADD && ({1'b0, da} > BCD_MAX || {1'b0, db} > BCD_MAX)) err <= 1'b1;
  end
`else
  assign err = 1'b0;
`endif
endmodule

// File: tb/tb_bcd_add_seq.sv
// tb_bcd_add_seq: randomized self-checking bench; reference model uses plain decimal arithmetic.
module tb_bcd_add_seq;
  localparam int DIGITS = 4;
  localparam int MODV = 10 ** DIGITS;
`ifdef BCD_SEQ_ERR_EN
  localparam logic ERR_ON = 1'b1;
`else
  localparam logic ERR_ON = 1'b0;
`endif
  logic MAX10_CLK1_50 = 1'b0;
  logic RESET_N = 1'b0;
  logic [3:0] digit_in = '0;
  logic load_a = 1'b0, load_b = 1'b0, clear = 1'b0, start = 1'b0;
  logic busy, done, cout, err;
  logic [4*DIGITS-1:0] result;
  int n_chk = 0, n_fail = 0;
  int ma = 0, mb = 0;
  int lat, bcnt, got_res;
  logic got_cout, got_busy_at_done;

  bcd_add_seq #(.DIGITS(DIGITS)) dut (
    .MAX10_CLK1_50(MAX10_CLK1_50), .RESET_N(RESET_N), .digit_in(digit_in),
    .load_a(load_a), .load_b(load_b), .clear(clear), .start(start),
    .busy(busy), .done(done), .result(result), .cout(cout), .err(err)
  );

  always #5 MAX10_CLK1_50 = ~MAX10_CLK1_50;

  task automatic tick();
    @(posedge MAX10_CLK1_50);
    #1;
  endtask

  function automatic int bcd2int(input logic [4*DIGITS-1:0] v);
    int r = 0;
    for (int i = DIGITS - 1; i >= 0; i--) r = r * 10 + int'(v[4*i +: 4]);
    return r;
  endfunction

  task automatic load(input bit la, input bit lb, input int d);
    digit_in = 4'(d);
    load_a = la;
    load_b = lb;
    tick();
    load_a = 0;
    load_b = 0;
    if (la) ma = (ma * 10 + d) % MODV;
    if (lb) mb = (mb * 10 + d) % MODV;
  endtask

  task automatic load_num(input bit is_a, input int v);
    for (int i = DIGITS - 1; i >= 0; i--) load(is_a, !is_a, (v / (10 ** i)) % 10);
  endtask

  task automatic do_clear();
    clear = 1;
    tick();
    clear = 0;
    ma = 0;
    mb = 0;
  endtask

  // Pulses start, waits (bounded) for done, records latency and busy count, then returns in IDLE.
  task automatic run_add();
    start = 1;
    tick();
    start = 0;
    lat = 1;
    bcnt = 0;
    while (!done && lat < 20) begin
      bcnt += int'(busy);
      tick();
      lat++;
    end
    got_res = bcd2int(result);
    got_cout = cout;
    got_busy_at_done = busy;
    tick();
  endtask

  task automatic check_sum(input string name);
    int exp_res = (ma + mb) % MODV;
    logic exp_c = (ma + mb) >= MODV;
    n_chk++;
    if (lat != DIGITS + 1) begin n_fail++; $display("FAIL %s latency got %0d want %0d", name, lat, DIGITS + 1); end
    n_chk++;
    if (got_res != exp_res) begin n_fail++; $display("FAIL %s result got %0d want %0d (a=%0d b=%0d)", name, got_res, exp_res, ma, mb); end
    n_chk++;
    if (got_cout !== exp_c) begin n_fail++; $display("FAIL %s cout got %0b want %0b", name, got_cout, exp_c); end
  endtask

  task automatic test_reset();
    RESET_N = 0;
    tick();
    tick();
    RESET_N = 1;
    n_chk++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset busy got %0b want 0", busy); end
    n_chk++;
    if (done !== 1'b0) begin n_fail++; $display("FAIL reset done got %0b want 0", done); end
    n_chk++;
    if (result !== '0) begin n_fail++; $display("FAIL reset result got %h want 0", result); end
    n_chk++;
    if (cout !== 1'b0) begin n_fail++; $display("FAIL reset cout got %0b want 0", cout); end
    n_chk++;
    if (err !== 1'b0) begin n_fail++; $display("FAIL reset err got %0b want 0", err); end
    ma = 0;
    mb = 0;
  endtask

  task automatic test_directed();
    load_num(1, 1234);
    load_num(0, 5678);
    run_add();
    check_sum("add_1234_5678");
    n_chk++;
    if (bcnt != DIGITS) begin n_fail++; $display("FAIL busy_cycles got %0d want %0d", bcnt, DIGITS); end
    n_chk++;
    if (got_busy_at_done !== 1'b0) begin n_fail++; $display("FAIL busy_at_done got %0b want 0", got_busy_at_done); end
    n_chk++;
    if (got_res != 6912) begin n_fail++; $display("FAIL const_6912 got %0d want 6912", got_res); end
    load_num(1, 9999);
    load_num(0, 1);
    run_add();
    check_sum("add_9999_0001");
    load_num(0, 9999);
    run_add();
    check_sum("add_9999_9999");
    n_chk++;
    if (got_res != 9998 || got_cout !== 1'b1) begin n_fail++; $display("FAIL const_max got %0d/%0b want 9998/1", got_res, got_cout); end
  endtask

  task automatic test_random();
    for (int r = 0; r < 25; r++) begin
      int k = $urandom_range(1, DIGITS + 2);
      for (int j = 0; j < k; j++) begin
        int sel = $urandom_range(0, 2);
        load(sel != 1, sel != 0, $urandom_range(0, 9));
      end
      run_add();
      check_sum("random");
      if ($urandom_range(0, 2) == 0) begin
        run_add();
        check_sum("back_to_back");
      end
    end
  endtask

  task automatic test_ignore_in_add();
    int c;
    load_num(1, 4821);
    load_num(0, 3579);
    start = 1;
    tick();
    start = 0;
    digit_in = 4'd7;
    load_a = 1;
    clear = 1;
    tick();
    load_a = 0;
    clear = 0;
    c = 2;
    while (!done && c < 20) begin tick(); c++; end
    lat = c;
    got_res = bcd2int(result);
    got_cout = cout;
    tick();
    check_sum("ignore_in_add");
    run_add();
    check_sum("operands_kept");
    start = 1;
    tick();
    start = 0;
    tick();
    RESET_N = 0;
    tick();
    RESET_N = 1;
    ma = 0;
    mb = 0;
    n_chk++;
    if (busy !== 0 || done !== 0 || result !== '0 || cout !== 0 || err !== 0) begin
      n_fail++;
      $display("FAIL mid_add_reset got busy=%0b done=%0b result=%h cout=%0b err=%0b want all 0", busy, done, result, cout, err);
    end
    c = 0;
    for (int i = 0; i < DIGITS + 3; i++) begin c += int'(done); tick(); end
    n_chk++;
    if (c != 0) begin n_fail++; $display("FAIL no_done_after_reset got %0d pulses want 0", c); end
  endtask

  task automatic test_priority();
    load_num(1, 2468);
    load_num(0, 1357);
    digit_in = 4'd5;
    load_a = 1;
    load_b = 1;
    start = 1;
    tick();
    load_a = 0;
    load_b = 0;
    start = 0;
    lat = 1;
    while (!done && lat < 20) begin tick(); lat++; end
    got_res = bcd2int(result);
    got_cout = cout;
    tick();
    check_sum("start_beats_load");
    load(1, 1, 3);
    run_add();
    check_sum("load_both");
    clear = 1;
    start = 1;
    tick();
    clear = 0;
    start = 0;
    ma = 0;
    mb = 0;
    n_chk++;
    if (busy !== 1'b0 || result !== '0 || cout !== 1'b0) begin
      n_fail++;
      $display("FAIL clear_beats_start got busy=%0b result=%h cout=%0b want 0/0/0", busy, result, cout);
    end
    run_add();
    check_sum("after_clear_zero");
  endtask

  task automatic test_err();
    load(1, 0, 12);
    n_chk++;
    if (err !== ERR_ON) begin n_fail++; $display("FAIL err_on_load got %0b want %0b", err, ERR_ON); end
    run_add();
    n_chk++;
    if (err !== ERR_ON) begin n_fail++; $display("FAIL err_sticky got %0b want %0b", err, ERR_ON); end
    do_clear();
    n_chk++;
    if (err !== 1'b0) begin n_fail++; $display("FAIL err_clear got %0b want 0", err); end
    load_num(1, 555);
    load_num(0, 445);
    run_add();
    check_sum("post_err_add");
    n_chk++;
    if (err !== 1'b0) begin n_fail++; $display("FAIL err_valid_digits got %0b want 0", err); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_ignore_in_add();
    test_priority();
    test_err();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
